// File: rtl/mem_arbiter.sv
// Three-port arbiter (loader, CPU data, instruction fetch) in front of a shared
// single-port memory; one access every three cycles: IDLE -> CMD -> WAIT.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n_i,

    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic              ld_we_i,
    input  logic [DATA_W-1:0] ld_wdata_i,
    output logic              ld_ack_o,
    output logic [DATA_W-1:0] ld_rdata_o,

    input  logic              d_req_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic              d_we_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,

    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_ack_o,
    output logic [DATA_W-1:0] i_rdata_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;
    typedef enum logic [1:0] {GNT_LD, GNT_D, GNT_I} grant_t;

    state_t            state, state_nxt;
    grant_t            grant, grant_nxt;
    logic              last_fetch;
    logic              any_req;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] ld_rdata_q, d_rdata_q, i_rdata_q;

    assign any_req = ld_req_i | d_req_i | i_req_i;

    // Loader always wins; data and fetch take turns when both are pending.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_nxt = GNT_I;
        if (ld_req_i)
            grant_nxt = GNT_LD;
        else if (d_req_i && i_req_i)
            grant_nxt = last_fetch ? GNT_D : GNT_I;
        else if (d_req_i)
            grant_nxt = GNT_D;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = CMD;
            CMD:     state_nxt = WAIT;
            WAIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            grant      <= GNT_I;
            last_fetch <= 1'b1;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            ld_rdata_q <= '0;
            d_rdata_q  <= '0;
            i_rdata_q  <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                grant <= grant_nxt;
                case (grant_nxt)
                    GNT_LD: begin
                        addr_q  <= ld_addr_i;
                        we_q    <= ld_we_i;
                        wdata_q <= ld_wdata_i;
                    end
                    GNT_D: begin
                        addr_q     <= d_addr_i;
                        we_q       <= d_we_i;
                        wdata_q    <= d_wdata_i;
                        last_fetch <= 1'b0;
                    end
                    default: begin
                        // Fetch is read-only; write data simply holds.
                        addr_q     <= i_addr_i;
                        we_q       <= 1'b0;
                        last_fetch <= 1'b1;
                    end
                endcase
            end
            if (state == WAIT) begin
                case (grant)
                    GNT_LD:  ld_rdata_q <= mem_rdata_i;
                    GNT_D:   d_rdata_q  <= mem_rdata_i;
                    default: i_rdata_q  <= mem_rdata_i;
                endcase
            end
        end
    end

    // Acks are gated by reset so an access interrupted in WAIT is never acknowledged.
    always_comb begin
        busy_o      = (state != IDLE);
        mem_we_o    = (state == CMD) && we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        ld_ack_o    = 1'b0;
        d_ack_o     = 1'b0;
        i_ack_o     = 1'b0;
        if (state == WAIT && rst_n_i) begin
            case (grant)
                GNT_LD:  ld_ack_o = 1'b1;
                GNT_D:   d_ack_o  = 1'b1;
                default: i_ack_o  = 1'b1;
            endcase
        end
        ld_rdata_o = ld_ack_o ? mem_rdata_i : ld_rdata_q;
        d_rdata_o  = d_ack_o  ? mem_rdata_i : d_rdata_q;
        i_rdata_o  = i_ack_o  ? mem_rdata_i : i_rdata_q;
    end

endmodule
